// File: rtl/wb_generic_byte_en_sram_if.sv
// Request/response bundle between the byte-enable SRAM bridge (master)
// and the byte-lane-writable SRAM target (slave).
interface wb_generic_byte_en_sram_if #(
   parameter int unsigned NUM_ADDR_BITS = 10,
   parameter int unsigned NUM_DATA_BITS = 32
);
   localparam int unsigned NB = NUM_DATA_BITS / 8;

   logic [NUM_ADDR_BITS-1:0] addr;
   logic                     read_en;
   logic                     write_en;
   logic [NB-1:0]            byte_en;
   logic [NUM_DATA_BITS-1:0] write_data;
   logic [NUM_DATA_BITS-1:0] read_data;
   logic                     init_done;

   modport master (
      output addr,
      output read_en,
      output write_en,
      output byte_en,
      output write_data,
      input  read_data,
      input  init_done
   );

   modport slave (
      input  addr,
      input  read_en,
      input  write_en,
      input  byte_en,
      input  write_data,
      output read_data,
      output init_done
   );
endinterface

// File: rtl/wb_generic_byte_en_sram.sv
// Single-port byte-lane-writable SRAM with 1-cycle registered reads and an
// optional post-reset zero-fill engine that owns the write port until the
// whole array has been cleared.
module wb_generic_byte_en_sram #(
   parameter int unsigned NUM_ADDR_BITS = 10,
   parameter int unsigned NUM_DATA_BITS = 32,
   parameter bit          INIT_CLEAR    = 1'b1
) (
   input  logic                      clk,
   input  logic                      rstn,
   wb_generic_byte_en_sram_if.slave  bus
);
   localparam int unsigned NB    = NUM_DATA_BITS / 8;
   localparam int unsigned DEPTH = 1 << NUM_ADDR_BITS;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_DONE  = 1'b1
   } state_t;

   state_t                    r_state;
   logic [NUM_ADDR_BITS-1:0]  r_cnt;
   logic                      r_init_done;
   logic [NUM_DATA_BITS-1:0]  r_read_data;

   // Array organised as NB byte lanes so it maps onto byte-write RAMs.
   logic [NB-1:0][7:0]        r_mem [0:DEPTH-1];

   logic [NB-1:0]             w_lane_we;
   logic [NUM_ADDR_BITS-1:0]  w_wr_addr;
   logic [NB-1:0][7:0]        w_wr_data;
   logic                      w_rd_accept;

   // Write-port mux: the clear engine owns the port while in CLEAR; reset
   // itself never writes the array.
   always_comb begin
      w_lane_we   = '0;
      w_wr_addr   = bus.addr;
      w_wr_data   = bus.write_data;
      w_rd_accept = 1'b0;
      if (rstn) begin
         if (r_state == S_CLEAR) begin
            w_lane_we = '1;
            w_wr_addr = r_cnt;
            w_wr_data = '0;
         end else if (bus.write_en) begin
            w_lane_we = bus.byte_en;
         end else if (bus.read_en) begin
            w_rd_accept = 1'b1;
         end
      end
   end

   // Per-lane array write; unselected lanes keep their contents.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NB; i++) begin
         if (w_lane_we[i]) begin
            r_mem[w_wr_addr][i] <= w_wr_data[i];
         end
      end
   end

   // Clear FSM, init_done flag and registered read data.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_read_data <= '0;
         r_cnt       <= '0;
         if (INIT_CLEAR) begin
            r_state     <= S_CLEAR;
            r_init_done <= 1'b0;
         end else begin
            r_state     <= S_DONE;
            r_init_done <= 1'b1;
         end
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_cnt <= r_cnt + NUM_ADDR_BITS'(1);
               if (r_cnt == '1) begin
                  r_state     <= S_DONE;
                  r_init_done <= 1'b1;
               end
            end
            S_DONE: begin
               if (w_rd_accept) begin
                  r_read_data <= r_mem[bus.addr];
               end
            end
            default: begin
               r_state <= S_DONE;
            end
         endcase
      end
   end

   assign bus.read_data = r_read_data;
   assign bus.init_done = r_init_done;

endmodule

// File: doc/wb_generic_byte_en_sram.md
Name: wb_generic_byte_en_sram

Overview:
Single-port, byte-lane-writable SRAM target that sits directly downstream of the Wishbone-to-byte-enable-SRAM bridge and consumes its generic_sram_byte_en request stream.
- Provides registered reads with exactly 1-cycle latency. This matches the bridge's read ACK, which is delayed one cycle relative to writes.
- Provides per-byte writes.
- Includes an optional post-reset clear engine that zeroes the whole array before accepting traffic.

Parameters:
NUM_ADDR_BITS, 10, word-address width; depth = 2**NUM_ADDR_BITS words
NUM_DATA_BITS, 32, word width; must be a multiple of 8; byte lanes NB = NUM_DATA_BITS/8
INIT_CLEAR, 1, 1 = run the zero-fill sequence after every reset; 0 = skip it (contents undefined)

Ports:
clk  input  1  clock; all state updates on the rising edge
rstn  input  1  reset, synchronous, active-low
addr  input  NUM_ADDR_BITS  word address from the bridge (word index, not a byte address)
read_en  input  1  read request, single-cycle qualified
write_en  input  1  write request, single-cycle qualified
byte_en  input  NB  byte-lane write enables; bit i covers data bits [8i+7:8i]
write_data  input  NUM_DATA_BITS  write data
read_data  output  NUM_DATA_BITS  registered read data
init_done  output  1  high when the array accepts requests

Behaviour:
Reset (rstn==0 at a clock edge):
- read_data <= 0.
- init_done <= 0 if INIT_CLEAR=1, else init_done <= 1.
- Clear FSM <= CLEAR with clear address counter <= 0 if INIT_CLEAR=1, else FSM <= DONE.
- Array contents are not touched by reset itself.

Clear FSM (INIT_CLEAR=1), states CLEAR and DONE:
- CLEAR: each cycle write all-zero to mem[cnt], then cnt <= cnt+1.
- When cnt == 2**NUM_ADDR_BITS-1, that final word is written and the FSM moves to DONE; init_done rises on the same edge.
- Total: exactly 2**NUM_ADDR_BITS cycles from the first clock with rstn=1 until init_done=1.
- All read_en/write_en/byte_en inputs are ignored while in CLEAR. read_data holds 0.
- Reset asserted mid-CLEAR: counter restarts from 0 and the full sequence reruns.
- DONE is terminal until the next reset.

Normal operation (DONE):
- Write, write_en=1: for each i with byte_en[i]=1, mem[addr] lane i <= write_data lane i. Other lanes unchanged.
  - byte_en all-zero: no change.
  - read_data unchanged on a write cycle.
- Read, read_en=1 and write_en=0: read_data <= mem[addr] (full word, byte_en ignored) on the same edge, so data is valid in the cycle after the request.
- Hold: read_data holds its value until the next accepted read. Idle cycles and writes do not disturb it.
- Both read_en and write_en high: write performed, read ignored, read_data holds. The bridge never does this; defined for robustness.
- Read-after-write: a read of the same address in the cycle after a write returns the merged new word. No bypass path is needed because the accesses are sequential.
- Back-to-back reads, one per cycle: read_data tracks with exactly 1-cycle lag; no bubbles, no stall capability.
- addr is always in range (full NUM_ADDR_BITS decode); no wrap logic beyond natural width.

Structure:
- Array is inferable as NB byte-wide RAMs or one RAM with byte-write enables.
- Clear writes share the single write port through a mux selected by FSM state.
- No combinational path from inputs to read_data.

Test Plan:
- Clear sequence, INIT_CLEAR=1, NUM_ADDR_BITS=4: release rstn -> init_done low for exactly 16 cycles, then high. Read every address -> 0x00000000 each, 1 cycle after read_en.
- Byte-lane writes: write 0xAABBCCDD byte_en=4'hF to addr 3, then 0x11223344 byte_en=4'b0101 -> read addr 3 next cycle returns 0xAA22CC44. A write with byte_en=0 leaves it unchanged.
- Read latency and hold: read addr 3 (0xAA22CC44), then idle 5 cycles, then write addr 3 -> read_data valid exactly 1 cycle after read_en and stays 0xAA22CC44 throughout.
- Back-to-back reads of addrs 0,1,2 holding 0x10,0x20,0x30 -> read_data shows 0x10,0x20,0x30 on consecutive cycles.
- Traffic during clear: write 0xFFFFFFFF to addr 5 while init_done=0 -> after done, addr 5 reads 0. Assert rstn=0 at clear cycle 7 -> init_done rises 16 cycles after release.
- Simultaneous read_en+write_en with 0x12345678 to addr 2 -> read_data unchanged that cycle; subsequent read returns 0x12345678. INIT_CLEAR=0 -> init_done=1 the first cycle after reset.
